// File: rtl/bank_fifo_burst_writer.sv
// Write-side traffic source for BankFIFO soak tests: emits bursts of
// incrementing words with programmable idle gaps and keeps running counts.
module bank_fifo_burst_writer #(
    parameter int W         = 16,
    parameter int BURST_LEN = 256,
    parameter int GAP       = 2,
    parameter int BURSTS    = 0,
    parameter int SEED      = 0
) (
    input  logic         w_clk,
    input  logic         rstClk,
    input  logic         en,
    input  logic         w_ready,
    output logic         w_trigger,
    output logic [W-1:0] w_data,
    output logic         done,
    output logic [15:0]  burst_count,
    output logic [31:0]  word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAPW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]  LAST_BEAT = 16'(BURST_LEN - 1);
    localparam logic [15:0]  GAP_L     = 16'(GAP);
    localparam logic [15:0]  BURSTS_L  = 16'(BURSTS);
    localparam logic [W-1:0] SEED_L    = W'(SEED);

    state_t         state_r;
    logic           trig_r;
    logic [W-1:0]   data_r;
    logic           done_r;
    logic [15:0]    burst_r;
    logic [31:0]    words_r;
    logic [15:0]    beat_r;
    logic [15:0]    gap_r;
    logic           xfer_s;

    assign xfer_s = trig_r & w_ready;

    // Burst sequencer: every output is a register updated here.
    always_ff @(posedge w_clk or posedge rstClk) begin
        if (rstClk) begin
            state_r <= ST_IDLE;
            trig_r  <= 1'b0;
            data_r  <= SEED_L;
            done_r  <= 1'b0;
            burst_r <= 16'd0;
            words_r <= 32'd0;
            beat_r  <= 16'd0;
            gap_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        trig_r  <= 1'b1;
                        state_r <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (xfer_s) begin
                        data_r  <= data_r + {{(W-1){1'b0}}, 1'b1};
                        words_r <= words_r + 32'd1;
                        if (beat_r == LAST_BEAT) begin
                            beat_r  <= 16'd0;
                            burst_r <= burst_r + 16'd1;
                            // Completion outranks en; en is only looked at here.
                            if ((BURSTS_L != 16'd0) && ((burst_r + 16'd1) == BURSTS_L)) begin
                                trig_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end else if (!en) begin
                                trig_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end else if (GAP_L == 16'd0) begin
                                trig_r  <= 1'b1;
                                state_r <= ST_BURST;
                            end else begin
                                trig_r  <= 1'b0;
                                gap_r   <= GAP_L;
                                state_r <= ST_GAPW;
                            end
                        end else begin
                            beat_r <= beat_r + 16'd1;
                        end
                    end
                end
                ST_GAPW: begin
                    if (gap_r == 16'd1) begin
                        gap_r   <= 16'd0;
                        trig_r  <= en;
                        state_r <= en ? ST_BURST : ST_IDLE;
                    end else begin
                        gap_r <= gap_r - 16'd1;
                    end
                end
                ST_DONE: begin
                    trig_r <= 1'b0;
                end
                default: begin
                    trig_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_trigger   = trig_r;
    assign w_data      = data_r;
    assign done        = done_r;
    assign burst_count = burst_r;
    assign word_count  = words_r;

endmodule

// File: tb/tb_bank_fifo_burst_writer.sv
// Bench for bank_fifo_burst_writer: four differently-configured instances
// checked every cycle against a word-count based model plus literal pins.
module tb_bank_fifo_burst_writer;

    localparam int BL[4] = '{256, 4, 8, 20};
    localparam int GP[4] = '{2, 0, 2, 0};
    localparam int BN[4] = '{0, 3, 0, 0};
    localparam int SD[4] = '{0, 0, 240, 0};
    localparam int WD[4] = '{16, 16, 16, 4};

    logic        w_clk  = 1'b0;
    logic        rstClk = 1'b1;
    logic        en_v[4];
    logic        rdy_v[4];
    logic        trig_o[4];
    logic [15:0] data_o[4];
    logic        done_o[4];
    logic [15:0] bc_o[4];
    logic [31:0] wc_o[4];
    logic [3:0]  data_d;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: total accepted words since reset, request flag, gap left
    int m_words[4];
    int m_gap[4];
    bit m_trig[4];

    always #5 w_clk = ~w_clk;

    bank_fifo_burst_writer #(.W(16), .BURST_LEN(256), .GAP(2), .BURSTS(0), .SEED(0)) u0 (
        .w_clk(w_clk), .rstClk(rstClk), .en(en_v[0]), .w_ready(rdy_v[0]),
        .w_trigger(trig_o[0]), .w_data(data_o[0]), .done(done_o[0]),
        .burst_count(bc_o[0]), .word_count(wc_o[0]));
    bank_fifo_burst_writer #(.W(16), .BURST_LEN(4), .GAP(0), .BURSTS(3), .SEED(0)) u1 (
        .w_clk(w_clk), .rstClk(rstClk), .en(en_v[1]), .w_ready(rdy_v[1]),
        .w_trigger(trig_o[1]), .w_data(data_o[1]), .done(done_o[1]),
        .burst_count(bc_o[1]), .word_count(wc_o[1]));
    bank_fifo_burst_writer #(.W(16), .BURST_LEN(8), .GAP(2), .BURSTS(0), .SEED(240)) u2 (
        .w_clk(w_clk), .rstClk(rstClk), .en(en_v[2]), .w_ready(rdy_v[2]),
        .w_trigger(trig_o[2]), .w_data(data_o[2]), .done(done_o[2]),
        .burst_count(bc_o[2]), .word_count(wc_o[2]));
    bank_fifo_burst_writer #(.W(4), .BURST_LEN(20), .GAP(0), .BURSTS(0), .SEED(0)) u3 (
        .w_clk(w_clk), .rstClk(rstClk), .en(en_v[3]), .w_ready(rdy_v[3]),
        .w_trigger(trig_o[3]), .w_data(data_d), .done(done_o[3]),
        .burst_count(bc_o[3]), .word_count(wc_o[3]));

    assign data_o[3] = {12'd0, data_d};

    function automatic bit exp_done(input int i);
        return (BN[i] != 0) && ((m_words[i] / BL[i]) >= BN[i]);
    endfunction

    // Behavioural model: everything derives from the accepted-word total.
    always @(posedge w_clk or posedge rstClk) begin
        for (int i = 0; i < 4; i++) begin
            if (rstClk) begin
                m_words[i] <= 0;
                m_gap[i]   <= 0;
                m_trig[i]  <= 1'b0;
            end else if (!exp_done(i)) begin
                if (m_trig[i]) begin
                    if (rdy_v[i]) begin
                        m_words[i] <= m_words[i] + 1;
                        if (((m_words[i] + 1) % BL[i]) == 0) begin
                            if (BN[i] != 0 && ((m_words[i] + 1) / BL[i]) == BN[i]) m_trig[i] <= 1'b0;
                            else if (!en_v[i]) m_trig[i] <= 1'b0;
                            else if (GP[i] == 0) m_trig[i] <= 1'b1;
                            else begin
                                m_trig[i] <= 1'b0;
                                m_gap[i]  <= GP[i];
                            end
                        end
                    end
                end else if (m_gap[i] > 0) begin
                    m_gap[i] <= m_gap[i] - 1;
                    if (m_gap[i] == 1) m_trig[i] <= en_v[i];
                end else begin
                    m_trig[i] <= en_v[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, then compare every instance to the model.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge w_clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d.w_trigger", i), {31'd0, trig_o[i]}, {31'd0, m_trig[i]});
                chk($sformatf("u%0d.w_data", i), {16'd0, data_o[i]},
                    32'((SD[i] + m_words[i]) & ((1 << WD[i]) - 1)));
                chk($sformatf("u%0d.word_count", i), wc_o[i], 32'(m_words[i]));
                chk($sformatf("u%0d.burst_count", i), {16'd0, bc_o[i]},
                    32'((m_words[i] / BL[i]) & 16'hFFFF));
                chk($sformatf("u%0d.done", i), {31'd0, done_o[i]}, {31'd0, exp_done(i)});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            en_v[i]  = 1'b0;
            rdy_v[i] = 1'b1;
        end
        tick(3);
        chk("reset_data_u2", {16'd0, data_o[2]}, 32'h0000_00F0);
        rstClk = 1'b0;

        // defaults: latency, first burst, 2-cycle gap
        en_v[0] = 1'b1;
        tick(1);
        chk("a_first_trig", {31'd0, trig_o[0]}, 32'd1);
        chk("a_first_data", {16'd0, data_o[0]}, 32'd0);
        for (int k = 0; k < 400; k++) begin
            tick(1);
            if (wc_o[0] == 32'd256) break;
        end
        chk("a_burst1_wc", wc_o[0], 32'd256);
        chk("a_burst1_bc", {16'd0, bc_o[0]}, 32'd1);
        chk("a_burst1_data", {16'd0, data_o[0]}, 32'h0000_0100);
        chk("a_gap_cycle1", {31'd0, trig_o[0]}, 32'd0);
        tick(1);
        chk("a_gap_cycle2", {31'd0, trig_o[0]}, 32'd0);
        tick(1);
        chk("a_burst2_trig", {31'd0, trig_o[0]}, 32'd1);
        chk("a_burst2_data", {16'd0, data_o[0]}, 32'h0000_0100);

        // random back-pressure with a long stall
        for (int k = 0; k < 300; k++) begin
            rdy_v[0] = 1'($urandom_range(0, 1));
            tick(1);
        end
        rdy_v[0] = 1'b0;
        tick(50);
        for (int k = 0; k < 100; k++) begin
            rdy_v[0] = 1'($urandom_range(0, 1));
            tick(1);
        end
        rdy_v[0] = 1'b1;
        en_v[0]  = 1'b0;
        tick(300);
        chk("a_stopped_trig", {31'd0, trig_o[0]}, 32'd0);

        // BURSTS=3, BURST_LEN=4, GAP=0
        en_v[1] = 1'b1;
        tick(20);
        chk("b_done", {31'd0, done_o[1]}, 32'd1);
        chk("b_wc", wc_o[1], 32'd12);
        chk("b_data", {16'd0, data_o[1]}, 32'd12);
        chk("b_bc", {16'd0, bc_o[1]}, 32'd3);
        chk("b_trig", {31'd0, trig_o[1]}, 32'd0);

        // en drop at beat 1 of an 8-beat burst
        en_v[2] = 1'b1;
        tick(2);
        en_v[2] = 1'b0;
        tick(20);
        chk("c_wc_after_drop", wc_o[2], 32'd8);
        chk("c_trig_after_drop", {31'd0, trig_o[2]}, 32'd0);
        chk("c_data_after_drop", {16'd0, data_o[2]}, 32'h0000_00F8);
        en_v[2] = 1'b1;
        tick(1);
        chk("c_resume_trig", {31'd0, trig_o[2]}, 32'd1);
        chk("c_resume_data", {16'd0, data_o[2]}, 32'h0000_00F8);
        tick(3);
        rdy_v[2] = 1'b0;
        tick(2);
        chk("c_stall_data", {16'd0, data_o[2]}, 32'h0000_00FB);

        // asynchronous reset mid-burst while stalled
        #2 rstClk = 1'b1;
        #1;
        chk("c_rst_trig", {31'd0, trig_o[2]}, 32'd0);
        chk("c_rst_wc", wc_o[2], 32'd0);
        chk("c_rst_data", {16'd0, data_o[2]}, 32'h0000_00F0);
        chk("b_rst_done", {31'd0, done_o[1]}, 32'd0);
        chk("b_rst_bc", {16'd0, bc_o[1]}, 32'd0);
        tick(2);
        rstClk   = 1'b0;
        rdy_v[2] = 1'b1;
        tick(1);
        chk("c_restart_trig", {31'd0, trig_o[2]}, 32'd1);
        chk("c_restart_data", {16'd0, data_o[2]}, 32'h0000_00F0);
        tick(20);
        en_v[2] = 1'b0;

        // W=4 wrap inside a 20-word burst
        en_v[3] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (wc_o[3] == 32'd20) break;
        end
        chk("d_wc", wc_o[3], 32'd20);
        chk("d_data", {16'd0, data_o[3]}, 32'd4);
        chk("d_bc", {16'd0, bc_o[3]}, 32'd1);
        chk("d_trig", {31'd0, trig_o[3]}, 32'd1);
        en_v[3] = 1'b0;
        tick(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
